imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loaded at run time over a byte-serial port. It holds the core in reset until the image is complete.
// Optional IMEM_CHECKSUM_EN adds checksum_o, the mod-256 sum of the accepted load bytes.
module imem_loader #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid_i,
    input  logic [7:0]        load_byte_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    input  logic              reload_i,
    input  logic [31:0]       pc_address_i,
    output logic [31:0]       instr_o,
    output logic              core_rst_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              overflow_o,
`ifdef IMEM_CHECKSUM_EN
    output logic [7:0]        checksum_o,
`endif
    output logic              fetch_fault_o
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t              state_q;
    logic [1:0]          byte_idx_q;
    logic [ADDR_W:0]     word_ptr_q;
    logic [DEPTH-1:0]    valid_q;
    logic [23:0]         asm_q;
    logic                core_rst_q;
    logic                overflow_q;
    logic                fault_q;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]          cks_q;
`endif

    logic [31:0]         mem [DEPTH];

    logic                full;
    logic                accept;
    logic                commit;
    logic [31:0]         wdata_d;
    logic [ADDR_W-1:0]   fetch_idx;
    logic                fetch_ok;

    // word_ptr never exceeds DEPTH, so its top bit alone marks a full memory
    assign full         = word_ptr_q[ADDR_W];
    assign load_ready_o = (state_q == S_LOAD) && !full;
    assign accept       = load_valid_i && load_ready_o;
    assign commit       = accept && ((byte_idx_q == 2'd3) || load_last_i);

    // Lanes above the current byte are zero for a short final word
    always_comb begin
        wdata_d = '0;
        case (byte_idx_q)
            2'd0:    wdata_d = {24'h000000, load_byte_i};
            2'd1:    wdata_d = {16'h0000, load_byte_i, asm_q[7:0]};
            2'd2:    wdata_d = {8'h00, load_byte_i, asm_q[15:0]};
            default: wdata_d = {load_byte_i, asm_q};
        endcase
    end

    assign fetch_idx = pc_address_i[ADDR_W+1:2];
    assign fetch_ok  = (pc_address_i[1:0] == 2'b00) && (pc_address_i[31:ADDR_W+2] == '0);
    assign instr_o   = (fetch_ok && valid_q[fetch_idx]) ? mem[fetch_idx] : NOP_WORD;

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[word_ptr_q[ADDR_W-1:0]] <= wdata_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            byte_idx_q <= 2'd0;
            word_ptr_q <= '0;
            valid_q    <= '0;
            asm_q      <= '0;
            core_rst_q <= 1'b1;
            overflow_q <= 1'b0;
            fault_q    <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            cks_q      <= 8'h00;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    core_rst_q <= 1'b1;
                    if (accept) begin
                        case (byte_idx_q)
                            2'd0:    asm_q[7:0]   <= load_byte_i;
                            2'd1:    asm_q[15:8]  <= load_byte_i;
                            2'd2:    asm_q[23:16] <= load_byte_i;
                            default: ;
                        endcase
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_CHECKSUM_EN
                        cks_q      <= cks_q + load_byte_i;
`endif
                    end
                    if (commit) begin
                        valid_q[word_ptr_q[ADDR_W-1:0]] <= 1'b1;
                        word_ptr_q <= word_ptr_q + (ADDR_W+1)'(1);
                    end
                    if (load_valid_i && full) begin
                        overflow_q <= 1'b1;
                    end
                    // load_last ends the image even when its byte was dropped
                    if (load_valid_i && load_last_i) begin
                        state_q    <= S_RUN;
                        byte_idx_q <= 2'd0;
                    end
                end
                default: begin
                    if (reload_i) begin
                        state_q    <= S_LOAD;
                        core_rst_q <= 1'b1;
                        byte_idx_q <= 2'd0;
                        word_ptr_q <= '0;
                        valid_q    <= '0;
                        overflow_q <= 1'b0;
                        fault_q    <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                        cks_q      <= 8'h00;
`endif
                    end else begin
                        core_rst_q <= 1'b0;
                        if (!fetch_ok) begin
                            fault_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign core_rst_o    = core_rst_q;
    assign word_count_o  = word_ptr_q;
    assign overflow_o    = overflow_q;
    assign fetch_fault_o = fault_q;
`ifdef IMEM_CHECKSUM_EN
    assign checksum_o    = cks_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of per-cycle vectors plus sequences for overflow, checksum and mid-load reset.
module tb_imem_loader;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        reload;
    logic [31:0] pc_address;
    logic [31:0] instr;
    logic        core_rst;
    logic [8:0]  word_count;
    logic        overflow;
    logic        fetch_fault;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int total = 0;
    int bad   = 0;

    imem_loader #(.ADDR_W(8), .NOP_WORD(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid_i (load_valid),
        .load_byte_i  (load_byte),
        .load_last_i  (load_last),
        .load_ready_o (load_ready),
        .reload_i     (reload),
        .pc_address_i (pc_address),
        .instr_o      (instr),
        .core_rst_o   (core_rst),
        .word_count_o (word_count),
        .overflow_o   (overflow),
`ifdef IMEM_CHECKSUM_EN
        .checksum_o   (checksum),
`endif
        .fetch_fault_o(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        last;
        logic        rl;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        crst;
        logic [8:0]  wc;
        logic        rdy;
        logic        ovf;
        logic        flt;
        logic [7:0]  cks;
    } row_t;

    row_t tbl[22];

    function automatic row_t mk(logic v, logic [7:0] b, logic last, logic rl, logic [31:0] pc,
                                logic [31:0] ins, logic crst, logic [8:0] wc, logic rdy,
                                logic ovf, logic flt, logic [7:0] cks);
        row_t r;
        r.v = v; r.b = b; r.last = last; r.rl = rl; r.pc = pc;
        r.instr = ins; r.crst = crst; r.wc = wc; r.rdy = rdy;
        r.ovf = ovf; r.flt = flt; r.cks = cks;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: inputs driven at the falling edge, outputs sampled 1ns after the rising edge
    task automatic step(input logic v, input logic [7:0] b, input logic last,
                        input logic rl, input logic [31:0] pc);
        @(negedge clk);
        load_valid = v; load_byte = b; load_last = last; reload = rl; pc_address = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic setpc(input logic [31:0] pc);
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0; reload = 1'b0; pc_address = pc;
        #1;
    endtask

    initial begin
        int ready_bad;

        tbl[0]  = mk(1, 8'h13, 0, 0, 32'h0,   NOP,          1, 0, 1, 0, 0, 8'h13);
        tbl[1]  = mk(1, 8'h00, 0, 0, 32'h0,   NOP,          1, 0, 1, 0, 0, 8'h13);
        tbl[2]  = mk(1, 8'h00, 0, 0, 32'h0,   NOP,          1, 0, 1, 0, 0, 8'h13);
        tbl[3]  = mk(1, 8'h00, 0, 0, 32'h0,   32'h00000013, 1, 1, 1, 0, 0, 8'h13);
        tbl[4]  = mk(1, 8'h93, 0, 0, 32'h0,   32'h00000013, 1, 1, 1, 0, 0, 8'hA6);
        tbl[5]  = mk(1, 8'h00, 0, 0, 32'h0,   32'h00000013, 1, 1, 1, 0, 0, 8'hA6);
        tbl[6]  = mk(1, 8'h10, 0, 0, 32'h0,   32'h00000013, 1, 1, 1, 0, 0, 8'hB6);
        tbl[7]  = mk(1, 8'h00, 1, 0, 32'h0,   32'h00000013, 1, 2, 0, 0, 0, 8'hB6);
        tbl[8]  = mk(0, 8'h00, 0, 0, 32'h4,   32'h00100093, 0, 2, 0, 0, 0, 8'hB6);
        tbl[9]  = mk(0, 8'h00, 0, 0, 32'h8,   NOP,          0, 2, 0, 0, 0, 8'hB6);
        tbl[10] = mk(0, 8'h00, 0, 0, 32'h0,   32'h00000013, 0, 2, 0, 0, 0, 8'hB6);
        tbl[11] = mk(0, 8'h00, 0, 0, 32'h2,   NOP,          0, 2, 0, 0, 1, 8'hB6);
        tbl[12] = mk(0, 8'h00, 0, 0, 32'h400, NOP,          0, 2, 0, 0, 1, 8'hB6);
        tbl[13] = mk(1, 8'h55, 0, 0, 32'h0,   32'h00000013, 0, 2, 0, 0, 1, 8'hB6);
        tbl[14] = mk(0, 8'h00, 0, 1, 32'h0,   NOP,          1, 0, 1, 0, 0, 8'h00);
        tbl[15] = mk(1, 8'hAA, 0, 0, 32'h2,   NOP,          1, 0, 1, 0, 0, 8'hAA);
        tbl[16] = mk(1, 8'hBB, 0, 0, 32'h0,   NOP,          1, 0, 1, 0, 0, 8'h65);
        tbl[17] = mk(1, 8'hCC, 1, 0, 32'h0,   32'h00CCBBAA, 1, 1, 0, 0, 0, 8'h31);
        tbl[18] = mk(0, 8'h00, 0, 0, 32'h0,   32'h00CCBBAA, 0, 1, 0, 0, 0, 8'h31);
        tbl[19] = mk(0, 8'h00, 0, 1, 32'h0,   NOP,          1, 0, 1, 0, 0, 8'h00);
        tbl[20] = mk(1, 8'h77, 1, 1, 32'h0,   32'h00000077, 1, 1, 0, 0, 0, 8'h77);
        tbl[21] = mk(0, 8'h00, 0, 0, 32'h0,   32'h00000077, 0, 1, 0, 0, 0, 8'h77);

        rst = 1'b1; load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0;
        reload = 1'b0; pc_address = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset core_rst", 32'(core_rst), 32'd1);
        chk("reset load_ready", 32'(load_ready), 32'd1);
        chk("reset word_count", 32'(word_count), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset fetch_fault", 32'(fetch_fault), 32'd0);
        chk("reset instr", instr, NOP);
`ifdef IMEM_CHECKSUM_EN
        chk("reset checksum", 32'(checksum), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].v, tbl[i].b, tbl[i].last, tbl[i].rl, tbl[i].pc);
            chk($sformatf("row%0d instr", i), instr, tbl[i].instr);
            chk($sformatf("row%0d core_rst", i), 32'(core_rst), 32'(tbl[i].crst));
            chk($sformatf("row%0d word_count", i), 32'(word_count), 32'(tbl[i].wc));
            chk($sformatf("row%0d load_ready", i), 32'(load_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("row%0d fetch_fault", i), 32'(fetch_fault), 32'(tbl[i].flt));
`ifdef IMEM_CHECKSUM_EN
            chk($sformatf("row%0d checksum", i), 32'(checksum), 32'(tbl[i].cks));
`endif
        end

        // Fill all 256 words, then offer bytes to a full memory
        step(0, 8'h00, 0, 1, 32'h0);
        ready_bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (load_ready !== 1'b1) ready_bad++;
            step(1, 8'(i), 0, 0, 32'h0);
        end
        chk("fill ready held", 32'(ready_bad), 32'd0);
        chk("full load_ready", 32'(load_ready), 32'd0);
        chk("full word_count", 32'(word_count), 32'd256);
        chk("full overflow before", 32'(overflow), 32'd0);
        setpc(32'h0);
        chk("full instr word0", instr, 32'h03020100);
        setpc(32'h3FC);
        chk("full instr word255", instr, 32'hFFFEFDFC);
        step(1, 8'h5A, 0, 0, 32'h0);
        chk("overflow set", 32'(overflow), 32'd1);
        chk("overflow word_count", 32'(word_count), 32'd256);
`ifdef IMEM_CHECKSUM_EN
        chk("overflow checksum", 32'(checksum), 32'd0);
`endif
        step(1, 8'h5A, 1, 0, 32'h0);
        chk("full last core_rst", 32'(core_rst), 32'd1);
        step(0, 8'h00, 0, 0, 32'h0);
        chk("full last released", 32'(core_rst), 32'd0);
        chk("full last overflow kept", 32'(overflow), 32'd1);

        // Short image 01,02,FF
        step(0, 8'h00, 0, 1, 32'h0);
        step(1, 8'h01, 0, 0, 32'h0);
        step(1, 8'h02, 0, 0, 32'h0);
        step(1, 8'hFF, 1, 0, 32'h0);
        chk("short instr", instr, 32'h00FF0201);
`ifdef IMEM_CHECKSUM_EN
        chk("short checksum", 32'(checksum), 32'h02);
`endif
        step(0, 8'h00, 0, 0, 32'h0);
        step(0, 8'h00, 0, 1, 32'h0);
`ifdef IMEM_CHECKSUM_EN
        chk("reload checksum", 32'(checksum), 32'h00);
`endif
        chk("reload flags", {30'd0, overflow, fetch_fault}, 32'd0);

        // Asynchronous reset in the middle of a load
        for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 0, 0, 32'h0);
        chk("midload word_count", 32'(word_count), 32'd1);
        chk("midload instr", instr, 32'h43424140);
        @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst word_count", 32'(word_count), 32'd0);
        chk("rst instr", instr, NOP);
        chk("rst core_rst", 32'(core_rst), 32'd1);
        chk("rst load_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step(0, 8'h00, 0, 0, 32'h0);
        chk("after rst instr", instr, NOP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
